// File: rtl/saver_sd_card.sv
// Save engine: streams a core byte range over the ioctl upload port into a
// 512-byte sector buffer and writes each sector to an SD image slot from LBA 0.
module saver_sd_card #(
  parameter int ADDR_W = 23
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              save_req_i,
  input  logic [1:0]        save_sel_i,
  input  logic [ADDR_W-1:0] save_size_i,
  input  logic [3:0]        img_mounted_i,
  input  logic [31:0]       img_size_i,
  output logic              ioctl_upload_o,
  output logic [ADDR_W-1:0] ioctl_addr_o,
  output logic              ioctl_rd_o,
  input  logic [7:0]        ioctl_din_i,
  input  logic              ioctl_wait_i,
  output logic [31:0]       sd_lba_o,
  output logic [2:0]        sd_wr_o,
  input  logic              sd_busy_i,
  input  logic [8:0]        sd_byte_index_i,
  output logic [7:0]        sd_wr_data_o,
  input  logic              sd_done_i,
  output logic              saver_busy_o,
  output logic              save_done_o,
  output logic              save_err_o
);

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, PAD, WR_REQ, WR_WAIT, NEXT, DONE} state_t;

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q;
  logic [3:0][ADDR_W-1:0] size_q;
  logic [3:0]        present_q;
  logic [ADDR_W-1:0] addr_q, len_q, len_d, slot_sz;
  logic [8:0]        cnt_q;
  logic [1:0]        sel_q;
  logic [31:0]       lba_q;
  logic [2:0]        wr_q, wr_onehot;
  logic              upload_q, rd_q, busy_q, done_q, err_q, req_ok;
  logic [7:0]        buf_mem [512];
  logic [7:0]        wr_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      size_q    <= '0;
      present_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (img_mounted_i[i]) begin
          size_q[i]    <= img_size_i[ADDR_W-1:0];
          present_q[i] <= |img_size_i;
        end
      end
    end
  end

  always_comb begin
    slot_sz = size_q[save_sel_i];
    len_d   = (save_size_i < slot_sz) ? save_size_i : slot_sz;
    req_ok  = (save_sel_i != 2'd0) && present_q[save_sel_i] && (len_d != '0);
  end

  assign wr_onehot = 3'b001 << (sel_q - 2'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      sel_q    <= '0;
      lba_q    <= '0;
      wr_q     <= '0;
      upload_q <= 1'b0;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rd_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: if (save_req_i) begin
          if (req_ok) begin
            len_q    <= len_d;
            sel_q    <= save_sel_i;
            busy_q   <= 1'b1;
            upload_q <= 1'b1;
            addr_q   <= '0;
            cnt_q    <= '0;
            lba_q    <= '0;
            state_q  <= FETCH;
          end else begin
            err_q <= 1'b1;
          end
        end
        FETCH: if (!ioctl_wait_i) begin
          rd_q    <= 1'b1;
          state_q <= CAPTURE;
        end
        // din for addr_q is valid now; the buffer write happens in parallel
        CAPTURE: begin
          addr_q <= addr_q + ONE;
          cnt_q  <= cnt_q + 9'd1;
          if (cnt_q == 9'd511) begin
            wr_q    <= wr_onehot;
            state_q <= WR_REQ;
          end else if (addr_q + ONE == len_q) begin
            state_q <= PAD;
          end else begin
            state_q <= FETCH;
          end
        end
        PAD: begin
          cnt_q <= cnt_q + 9'd1;
          if (cnt_q == 9'd511) begin
            wr_q    <= wr_onehot;
            state_q <= WR_REQ;
          end
        end
        WR_REQ: if (sd_busy_i) begin
          wr_q    <= '0;
          state_q <= WR_WAIT;
        end
        WR_WAIT: if (sd_done_i) state_q <= NEXT;
        NEXT: begin
          lba_q   <= lba_q + 32'd1;
          cnt_q   <= '0;
          state_q <= (addr_q == len_q) ? DONE : FETCH;
        end
        DONE: begin
          done_q   <= 1'b1;
          upload_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sector buffer: port A fills from the core, port B feeds the SD controller
  always_ff @(posedge clk) begin
    if (state_q == CAPTURE)  buf_mem[cnt_q] <= ioctl_din_i;
    else if (state_q == PAD) buf_mem[cnt_q] <= 8'h00;
  end

  always_ff @(posedge clk) begin
    if (reset) wr_data_q <= '0;
    else       wr_data_q <= buf_mem[sd_byte_index_i];
  end

  assign ioctl_upload_o = upload_q;
  assign ioctl_addr_o   = addr_q;
  assign ioctl_rd_o     = rd_q;
  assign sd_lba_o       = lba_q;
  assign sd_wr_o        = wr_q;
  assign sd_wr_data_o   = wr_data_q;
  assign saver_busy_o   = busy_q;
  assign save_done_o    = done_q;
  assign save_err_o     = err_q;

endmodule
